// File: rtl/multicycle_ctrl_irq.sv
// Multi-cycle CPU control FSM with a vectored, maskable, fixed-priority interrupt controller.
// Optional bus wait-state timeout is enabled by defining CTRL_BUS_TIMEOUT_EN.
module multicycle_ctrl_irq #(
    parameter int NUM_IRQ     = 4,
    parameter int VEC_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op_i,
    input  logic [2:0]         func_i,
    input  logic               inst_ack_i,
    input  logic               data_ack_i,
    input  logic               port_ack_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_mask_i,
    output logic               stb_o,
    output logic               cyc_o,
    output logic               pcen_o,
    output logic               data_stb_o,
    output logic               data_cyc_o,
    output logic               data_we_o,
    output logic               port_we_o,
    output logic               alu_en_o,
    output logic [3:0]         alu_op_o,
    output logic               regwrt_o,
    output logic               int_ack_o,
    output logic [VEC_W-1:0]   int_vec_o,
    output logic               ie_o,
    output logic               sleep_o,
    output logic               bus_err_o,
    output logic [2:0]         dbg_state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_INT    = 3'd5;
    localparam logic [2:0] S_SLEEP  = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]         state, state_next;
    logic               ie;
    logic [NUM_IRQ-1:0] pend, pend_clr, req;
    logic [VEC_W-1:0]   vec;
    logic is_alu_imm, is_alu_reg, is_shift, is_mem, is_misc, is_ctrl;
    logic is_reti, is_wait, is_ld, is_st, is_in, is_out;
    logic bus_ack, take_int, timed_out;

    assign is_alu_imm = ~op_i[6];
    assign is_alu_reg = (op_i[6:3] == 4'b1110);
    assign is_shift   = (op_i[6:4] == 3'b110);
    assign is_mem     = (op_i[6:5] == 2'b10);
    assign is_misc    = (op_i == 7'b1111110);
    // jump, branch, misc and the unassigned 1111111 all just return to fetch
    assign is_ctrl    = (op_i[6:3] == 4'b1111);
    assign is_reti    = is_misc & (func_i == 3'b001);
    assign is_wait    = is_misc & (func_i == 3'b100);
    assign is_ld      = is_mem & (func_i[2:1] == 2'b00);
    assign is_st      = is_mem & (func_i[2:1] == 2'b01);
    assign is_in      = is_mem & (func_i[2:1] == 2'b10);
    assign is_out     = is_mem & (func_i[2:1] == 2'b11);

    assign req      = pend & irq_mask_i;
    assign take_int = ie & (|req);

    always_comb begin
        bus_ack = 1'b0;
        if (state == S_FETCH)
            bus_ack = inst_ack_i;
        else if (state == S_MEM)
            bus_ack = (is_ld | is_st) ? data_ack_i : port_ack_i;
    end

    // Lowest index wins: scan downwards so the last hit is the smallest line.
    always_comb begin
        vec = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) vec = VEC_W'(i);
    end

    assign pend_clr = (state == S_INT && (|req)) ? (NUM_IRQ'(1) << vec) : '0;

`ifdef CTRL_BUS_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timed_out = ((state == S_FETCH) || (state == S_MEM)) && !bus_ack
                       && (wait_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 8'd0;
        else if (bus_ack || (state_next != state))
            wait_cnt <= 8'd0;
        else if ((state == S_FETCH) || (state == S_MEM))
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign bus_err_o = (state == S_ERR);
`else
    logic unused_cfg;
    assign unused_cfg = |8'(TIMEOUT_CYC);
    assign timed_out  = 1'b0;
    assign bus_err_o  = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (bus_ack) state_next = S_DECODE;
                      else if (timed_out) state_next = S_ERR;
            S_DECODE: if (is_wait) state_next = S_SLEEP;
                      else if (is_reti) state_next = S_FETCH;
                      else if (is_ctrl) state_next = take_int ? S_INT : S_FETCH;
                      else state_next = S_EXEC;
            S_EXEC:   state_next = is_mem ? S_MEM : S_WB;
            S_MEM:    if (bus_ack) state_next = (is_ld | is_in) ? S_WB : (take_int ? S_INT : S_FETCH);
                      else if (timed_out) state_next = S_ERR;
            S_WB:     state_next = take_int ? S_INT : S_FETCH;
            S_INT:    state_next = S_FETCH;
            S_SLEEP:  if (|req) state_next = ie ? S_INT : S_FETCH;
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ie    <= 1'b1;
            pend  <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE && is_reti)
                ie <= 1'b1;
            else if (state == S_INT)
                ie <= 1'b0;
            // a re-request arriving in the service cycle survives the clear
            pend <= (pend & ~pend_clr) | irq_i;
        end
    end

    always_comb begin
        alu_op_o = 4'b0000;
        if (state == S_DECODE || state == S_EXEC || state == S_WB) begin
            if (is_alu_imm || is_alu_reg) begin
                if (func_i != 3'b011 && func_i != 3'b100)
                    alu_op_o = {1'b0, func_i};
            end else if (is_shift) begin
                alu_op_o = {2'b10, func_i[1:0]};
            end
        end
    end

    assign stb_o      = (state == S_FETCH);
    assign cyc_o      = (state == S_FETCH);
    assign pcen_o     = (state == S_FETCH);
    assign data_stb_o = (state == S_MEM) && (is_ld || is_st);
    assign data_cyc_o = (state == S_MEM) && (is_ld || is_st);
    assign data_we_o  = (state == S_MEM) && is_st;
    assign port_we_o  = (state == S_MEM) && is_out;
    assign alu_en_o   = (state == S_EXEC) && !is_mem;
    assign regwrt_o   = (state == S_WB);
    assign int_ack_o  = (state == S_INT);
    assign int_vec_o  = (state == S_INT) ? vec : '0;
    assign ie_o       = ie;
    assign sleep_o    = (state == S_SLEEP);
    assign dbg_state  = state;

endmodule

// File: tb/tb_multicycle_ctrl_irq.sv
// Bench for multicycle_ctrl_irq: directed instructions, expected events queued by the driver
// and consumed by an independent monitor watching the DUT outputs.
module tb_multicycle_ctrl_irq;

    localparam int NUM_IRQ = 4;
    localparam int VEC_W   = 2;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEM = 3'd3, S_ERR = 3'd7;
    localparam logic [6:0] OP_MISC = 7'b1111110;
    localparam logic [6:0] OP_JUMP = 7'b1111000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [6:0]         op_i = '0;
    logic [2:0]         func_i = '0;
    logic               inst_ack_i = 1'b0, data_ack_i = 1'b0, port_ack_i = 1'b0;
    logic [NUM_IRQ-1:0] irq_i = '0;
    logic [NUM_IRQ-1:0] irq_mask_i = 4'b1111;
    logic               stb_o, cyc_o, pcen_o, data_stb_o, data_cyc_o, data_we_o, port_we_o;
    logic               alu_en_o, regwrt_o, int_ack_o, ie_o, sleep_o, bus_err_o;
    logic [3:0]         alu_op_o;
    logic [VEC_W-1:0]   int_vec_o;
    logic [2:0]         dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    multicycle_ctrl_irq #(.NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .func_i(func_i),
        .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i), .port_ack_i(port_ack_i),
        .irq_i(irq_i), .irq_mask_i(irq_mask_i),
        .stb_o(stb_o), .cyc_o(cyc_o), .pcen_o(pcen_o),
        .data_stb_o(data_stb_o), .data_cyc_o(data_cyc_o), .data_we_o(data_we_o),
        .port_we_o(port_we_o), .alu_en_o(alu_en_o), .alu_op_o(alu_op_o),
        .regwrt_o(regwrt_o), .int_ack_o(int_ack_o), .int_vec_o(int_vec_o),
        .ie_o(ie_o), .sleep_o(sleep_o), .bus_err_o(bus_err_o), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic check_ev(input logic [15:0] got);
        logic [15:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got %h with nothing expected", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                miscompares++;
                $display("FAIL event: got %h required %h", got, exp);
            end
        end
    endtask

    // Event words: [15:12] kind, [11:0] payload.
    //  1 decode : {alu_op, fetch cycles}
    //  2 wb     : {alu_op, alu_en of previous cycle, previous state, regwrt length}
    //  3 mem    : {0, data_stb all cycles, data_we, port_we, mem cycles}
    //  4 int    : vector
    //  5 sleep  : {0, state after sleep, sleep cycles}
    //  6 err    : fetch cycles before error
    initial begin : monitor
        logic [7:0] fetch_len, mem_len, sleep_len;
        logic [3:0] wb_len, wb_op;
        logic [2:0] prev_state, wb_prev_state;
        logic prev_regwrt, prev_sleep, prev_err, prev_alu_en, prev_we, prev_port_we;
        logic mem_stb_all, wb_alu_en;
        forever begin
            @(negedge clk);
            if (rst) begin
                fetch_len = 0; mem_len = 0; sleep_len = 0; wb_len = 0; wb_op = 0;
                prev_state = S_FETCH; wb_prev_state = 0; prev_regwrt = 0; prev_sleep = 0;
                prev_err = 0; prev_alu_en = 0; prev_we = 0; prev_port_we = 0;
                mem_stb_all = 0; wb_alu_en = 0;
            end else begin
                if (dbg_state == S_DECODE)
                    check_ev({4'd1, alu_op_o, fetch_len});
                if (prev_state == S_MEM && dbg_state != S_MEM)
                    check_ev({4'd3, 1'b0, mem_stb_all, prev_we, prev_port_we, mem_len});
                if (prev_regwrt && !regwrt_o)
                    check_ev({4'd2, wb_op, wb_alu_en, wb_prev_state, wb_len});
                if (prev_sleep && !sleep_o)
                    check_ev({4'd5, 1'b0, dbg_state, sleep_len});
                if (int_ack_o)
                    check_ev({4'd4, 10'd0, int_vec_o});
                if (bus_err_o && !prev_err)
                    check_ev({4'd6, 4'd0, fetch_len});

                fetch_len = (dbg_state == S_FETCH) ? fetch_len + 8'd1 : 8'd0;
                if (dbg_state == S_MEM) begin
                    if (prev_state != S_MEM) begin
                        mem_len = 1; mem_stb_all = data_stb_o;
                    end else begin
                        mem_len++; mem_stb_all &= data_stb_o;
                    end
                end
                if (regwrt_o) begin
                    if (!prev_regwrt) begin
                        wb_len = 1; wb_op = alu_op_o; wb_alu_en = prev_alu_en;
                        wb_prev_state = prev_state;
                    end else wb_len++;
                end
                if (sleep_o) sleep_len = prev_sleep ? sleep_len + 8'd1 : 8'd1;
                prev_state = dbg_state; prev_regwrt = regwrt_o; prev_sleep = sleep_o;
                prev_err = bus_err_o; prev_alu_en = alu_en_o; prev_we = data_we_o;
                prev_port_we = port_we_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input logic [2:0] st);
        int n = 0;
        while (dbg_state != st && n < 100) begin
            tick();
            n++;
        end
        if (dbg_state != st) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_state: state %0d required %0d", dbg_state, st);
        end
    endtask

    // Presents an instruction in FETCH, acking after 'delay' cycles; returns in DECODE.
    task automatic issue(input logic [6:0] op, input logic [2:0] func, input int delay);
        wait_state(S_FETCH);
        op_i = op;
        func_i = func;
        repeat (delay) tick();
        inst_ack_i = 1'b1;
        tick();
        inst_ack_i = 1'b0;
    endtask

    task automatic mem_ack(input logic port, input int delay);
        wait_state(S_MEM);
        repeat (delay) tick();
        if (port) port_ack_i = 1'b1; else data_ack_i = 1'b1;
        tick();
        port_ack_i = 1'b0;
        data_ack_i = 1'b0;
    endtask

    task automatic pulse_irq(input logic [NUM_IRQ-1:0] v);
        irq_i = v;
        tick();
        irq_i = '0;
    endtask

    task automatic push(input logic [15:0] ev);
        exp_q.push_back(ev);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_fetch_strobes", {stb_o, cyc_o, pcen_o}, 3'b111);
        check("rst_ie", ie_o, 1'b1);
        check("rst_others", {data_stb_o, data_cyc_o, data_we_o, port_we_o, alu_en_o, alu_op_o,
                             regwrt_o, int_ack_o, int_vec_o, sleep_o, bus_err_o}, 0);
        check("rst_state", dbg_state, S_FETCH);
        rst = 1'b0;

        // ALU / shift decoding
        push(16'h1103); push(16'h21A1); issue(7'b0000000, 3'b001, 2);
        push(16'h1701); push(16'h27A1); issue(7'b0011001, 3'b111, 0);
        push(16'h1002); push(16'h20A1); issue(7'b0101010, 3'b100, 1);
        push(16'h1201); push(16'h22A1); issue(7'b1110101, 3'b010, 0);
        push(16'h1001); push(16'h20A1); issue(7'b1110000, 3'b011, 0);
        push(16'h1B01); push(16'h2BA1); issue(7'b1100000, 3'b111, 0);

        // memory and port accesses
        push(16'h1001); push(16'h3404); push(16'h2031); issue(7'b1000000, 3'b000, 0); mem_ack(1'b0, 3);
        push(16'h1001); push(16'h3602); issue(7'b1011111, 3'b010, 0); mem_ack(1'b0, 1);
        push(16'h1001); push(16'h3101); issue(7'b1000000, 3'b110, 0); mem_ack(1'b1, 0);
        push(16'h1001); push(16'h3003); push(16'h2031); issue(7'b1000000, 3'b100, 0); mem_ack(1'b1, 2);

        // jump and branch
        push(16'h1001); issue(7'b1111011, 3'b000, 0);
        push(16'h1001); issue(7'b1111101, 3'b101, 0);

        // two lines at once: line 1 first, line 2 only after reti re-enables
        push(16'h1101); push(16'h21A1); push(16'h4001);
        issue(7'b0000000, 3'b001, 0); pulse_irq(4'b0110);
        push(16'h1201); push(16'h22A1); issue(7'b0000111, 3'b010, 0);
        push(16'h1001); issue(OP_MISC, 3'b001, 0);
        push(16'h1001); push(16'h4002); issue(OP_JUMP, 3'b000, 0);
        push(16'h1001); issue(OP_MISC, 3'b001, 0);

        // masked line latches but is held off until unmasked
        irq_mask_i = 4'b1110;
        irq_i = 4'b0001;
        push(16'h1001); push(16'h20A1); issue(7'b0000000, 3'b000, 0);
        irq_i = '0;
        wait_state(S_FETCH);
        irq_mask_i = 4'b1111;
        push(16'h1001); push(16'h4000); issue(OP_JUMP, 3'b000, 0);
        push(16'h1001); issue(OP_MISC, 3'b001, 0);

        // wait with ie set: wake into INT
        push(16'h1001); push(16'h5504); push(16'h4003);
        issue(OP_MISC, 3'b100, 0);
        repeat (3) tick();
        pulse_irq(4'b1000);

        // wait with ie clear: wake into FETCH, line stays pending
        push(16'h1001); push(16'h5002);
        issue(OP_MISC, 3'b100, 0);
        tick();
        pulse_irq(4'b0100);
        push(16'h1001); issue(OP_MISC, 3'b001, 0);
        push(16'h1001); push(16'h4002); issue(OP_JUMP, 3'b000, 0);
        push(16'h1001); issue(OP_MISC, 3'b001, 0);

        wait_state(S_FETCH);
        repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);

        // reset in the middle of a store
        push(16'h1003); issue(7'b1011111, 3'b010, 0);
        wait_state(S_MEM);
        check("st_we_before_rst", {data_we_o, data_stb_o}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("st_we_async_drop", {data_we_o, data_stb_o, data_cyc_o}, 3'b000);
        check("st_rst_fetch", {stb_o, dbg_state}, {1'b1, S_FETCH});
        tick();
        rst = 1'b0;
        check("after_rst_state_ie", {dbg_state, ie_o}, {S_FETCH, 1'b1});

`ifdef CTRL_BUS_TIMEOUT_EN
        rst = 1'b1;
        tick();
        push(16'h6004);
        rst = 1'b0;
        repeat (8) tick();
        check("timeout_err", {bus_err_o, stb_o, dbg_state}, {1'b1, 1'b0, S_ERR});
        check("timeout_drained", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        check("timeout_cleared", bus_err_o, 1'b0);
`else
        repeat (8) tick();
        check("no_timeout", {bus_err_o, dbg_state}, {1'b0, S_FETCH});
        rst = 1'b1;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
